// File: rtl/serial_addsub_ctrl.sv
// Bit-serial adder/subtractor: one full-adder cell is stepped over WIDTH
// cycles, LSB first. Subtraction is a + ~b + 1, with the +1 entering as the
// initial carry. Start/done handshake; results held until the next operation.

// Single-bit full adder cell shared by every bit position.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_addsub_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   op_a_q;
  logic [WIDTH-1:0]   op_b_q;
  logic               carry_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   result_q;
  logic               busy_q;
  logic               done_q;
  logic               cout_q;
  logic               overflow_q;

  logic               fa_sum;
  logic               fa_cout;

  // The one arithmetic cell: always looks at the current LSBs and carry.
  fulladder u_fa (
    .a    (op_a_q[0]),
    .b    (op_b_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Control FSM plus datapath shift registers, all with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_a_q     <= '0;
      op_b_q     <= '0;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
      result_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cout_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            // Operands are latched here so later input changes are harmless.
            op_a_q  <= a;
            op_b_q  <= mode ? ~b : b;
            carry_q <= mode;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end
        end

        S_RUN: begin
          result_q <= {fa_sum, result_q[WIDTH-1:1]};
          op_a_q   <= op_a_q >> 1;
          op_b_q   <= op_b_q >> 1;
          carry_q  <= fa_cout;
          if (cnt_q == CNT_LAST) begin
            // On the MSB step carry_q is the carry into the MSB, so the
            // signed overflow is simply carry-in XOR carry-out of this bit.
            cout_q     <= fa_cout;
            overflow_q <= carry_q ^ fa_cout;
            done_q     <= 1'b1;
            state_q    <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        S_DONE: begin
          // start is deliberately not sampled here; it must be seen in IDLE.
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign cout     = cout_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Testbench for serial_addsub_ctrl: directed test-plan cases with literal
// expectations, exhaustive WIDTH=4 sweep and randomized start/reset traffic,
// all checked every cycle against an arithmetic reference model.
module tb_serial_addsub_ctrl;

  localparam int W = 4;
  localparam longint MOD = 64'd1 << W;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         mode = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         overflow;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;

  serial_addsub_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mode     (mode),
    .a        (a_in),
    .b        (b_in),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cycle);
    end
  endtask

  // ---------------- reference model ----------------
  // left = cycles until the handshake returns to idle; 0 means idle,
  // 1 means the done cycle, anything else means the operation is in flight.
  int           left = 0;
  bit           model_on = 0;
  logic [W-1:0] la, lb;
  logic         lm;
  logic [W-1:0] exp_result = '0;
  logic         exp_cout = 0;
  logic         exp_ovf = 0;

  task automatic compute(input logic [W-1:0] x, input logic [W-1:0] y, input logic m,
                         output logic [W-1:0] r, output logic c, output logic v);
    longint ux, uy, sx, sy, full, sres;
    ux = longint'(x);
    uy = longint'(y);
    sx = x[W-1] ? ux - MOD : ux;
    sy = y[W-1] ? uy - MOD : uy;
    if (m) begin
      full = ux + (MOD - 1 - uy) + 1;  // a + ~b + 1
      sres = sx - sy;
    end else begin
      full = ux + uy;
      sres = sx + sy;
    end
    r = W'(full % MOD);
    c = (full >= MOD);
    v = (sres > (MOD / 2 - 1)) || (sres < -(MOD / 2));
  endtask

  always @(posedge clk) begin
    cycle++;
    if (rst) begin
      model_on   = 1;
      left       = 0;
      exp_result = '0;
      exp_cout   = 0;
      exp_ovf    = 0;
    end else if (left == 0) begin
      if (start) begin
        la = a_in; lb = b_in; lm = mode;
        left = W + 1;
      end
    end else begin
      left--;
      if (left == 1) compute(la, lb, lm, exp_result, exp_cout, exp_ovf);
    end
  end

  // ---------------- per-cycle compare ----------------
  int done_times[$];

  always @(negedge clk) begin
    if (model_on) begin
      chk("busy", 32'(busy), 32'(left != 0));
      chk("done", 32'(done), 32'(left == 1));
      chk("cout", 32'(cout), 32'(exp_cout));
      chk("overflow", 32'(overflow), 32'(exp_ovf));
      if (left < 2) chk("result", 32'(result), 32'(exp_result));
      if (done === 1'b1) done_times.push_back(cycle);
    end
  end

  // ---------------- stimulus helpers ----------------
  // Issue one operation from idle; report latency (cycle index of done
  // counted from the accept edge) and the number of busy cycles.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tm,
                       output int done_cyc, output int busy_cnt);
    @(posedge clk); #1;
    start = 1'b1; a_in = ta; b_in = tb; mode = tm;
    @(posedge clk); #1;
    start = 1'b0;
    a_in = W'($urandom); b_in = W'($urandom); mode = 1'($urandom);
    done_cyc = 0;
    busy_cnt = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        done_cyc = k;
        break;
      end
    end
    if (done_cyc == 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  int dc, bc, ndone;

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_cout_ovf", 32'({cout, overflow}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 0101 + 0011
    do_op(4'b0101, 4'b0011, 1'b0, dc, bc);
    chk("t1_done_cycle", 32'(dc), 32'(W + 1));
    chk("t1_busy_cycles", 32'(bc), 32'(W + 1));
    chk("t1_result", 32'(result), 32'b1000);
    chk("t1_cout_ovf", 32'({cout, overflow}), 32'b01);

    // 0011 - 0101
    do_op(4'b0011, 4'b0101, 1'b1, dc, bc);
    chk("t2_result", 32'(result), 32'b1110);
    chk("t2_cout_ovf", 32'({cout, overflow}), 32'b00);

    // 1111 + 0001, then 1000 - 0001
    do_op(4'b1111, 4'b0001, 1'b0, dc, bc);
    chk("t3_result", 32'(result), 32'b0000);
    chk("t3_cout_ovf", 32'({cout, overflow}), 32'b10);
    do_op(4'b1000, 4'b0001, 1'b1, dc, bc);
    chk("t4_result", 32'(result), 32'b0111);
    chk("t4_cout_ovf", 32'({cout, overflow}), 32'b11);

    // Results held after done while idle
    repeat (3) @(negedge clk);
    chk("hold_result", 32'(result), 32'b0111);

    // Reset in the middle of RUN
    @(posedge clk); #1;
    start = 1'b1; a_in = 4'b0110; b_in = 4'b0001; mode = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy_done", 32'({busy, done}), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_cout_ovf", 32'({cout, overflow}), 32'd0);
    ndone = done_times.size();
    repeat (10) @(negedge clk);
    chk("abort_no_done", 32'(done_times.size() - ndone), 32'd0);
    do_op(4'b0110, 4'b0001, 1'b0, dc, bc);
    chk("after_abort_result", 32'(result), 32'b0111);
    chk("after_abort_cout_ovf", 32'({cout, overflow}), 32'b00);

    // start held high with changing operands: back-to-back at 6-cycle spacing
    @(posedge clk); #1;
    done_times.delete();
    start = 1'b1;
    for (int i = 0; i < 14; i++) begin
      a_in = W'($urandom); b_in = W'($urandom); mode = 1'($urandom);
      @(posedge clk); #1;
    end
    start = 1'b0;
    repeat (8) @(posedge clk);
    chk("b2b_count_ge2", 32'(done_times.size() >= 2), 32'd1);
    for (int i = 1; i < done_times.size(); i++)
      chk("b2b_spacing", 32'(done_times[i] - done_times[i-1]), 32'(W + 2));

    // Exhaustive sweep (checked per cycle against the model)
    for (int m = 0; m < 2; m++)
      for (int x = 0; x < (1 << W); x++)
        for (int y = 0; y < (1 << W); y++) begin
          do_op(W'(x), W'(y), 1'(m), dc, bc);
          chk("sweep_latency", 32'(dc), 32'(W + 1));
        end

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      start = ($urandom_range(0, 2) == 0);
      a_in  = W'($urandom);
      b_in  = W'($urandom);
      mode  = 1'($urandom);
      rst   = ($urandom_range(0, 150) == 0);
    end
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
